// File: rtl/hazard_control.sv
// hazard_control: EX/ID forwarding selects, load-use/branch/MDU stall generation, MDU busy tracker, stall counter.
// Latency: forwarding and stall outputs are combinational; mdu_busy and stall_count are registered.
// Backpressure: a single stall freezes PC and IF/ID and bubbles ID/EX. Optional build macro HAZARD_BRANCH_FWD_EN.
module hazard_control #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  write_addr_E,
    input  logic [4:0]  write_addr_M,
    input  logic [4:0]  write_addr_W,
    input  logic        reg_write_E,
    input  logic        reg_write_M,
    input  logic        reg_write_W,
    input  logic        mem_to_reg_E,
    input  logic        mem_to_reg_M,
    input  logic        branch_D,
    input  logic        mdu_op_D,
    input  logic        hilo_read_D,
    input  logic        mdu_start_E,
    input  logic        mdu_is_div_E,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic [1:0]  forward_A_E,
    output logic [1:0]  forward_B_E,
    output logic        forward_A_D,
    output logic        forward_B_D,
    output logic        mdu_busy,
    output logic [15:0] stall_count
);

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_t;

    mdu_state_t  state_q;
    logic [5:0]  mdu_cnt_q;
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_d;

    logic lw_stall;
    logic branch_stall;
    logic mdu_stall;
    logic stall;

    // A producer matches a source only when it writes and the destination is not r0.
    function automatic logic dep(input logic we, input logic [4:0] wa, input logic [4:0] src);
        return we && (wa != 5'd0) && (wa == src);
    endfunction

    // EX operand selects: MEM result is newer than WB, so it takes priority.
    always_comb begin
        forward_A_E = 2'b00;
        forward_B_E = 2'b00;
        if (dep(reg_write_M, write_addr_M, rs_E))      forward_A_E = 2'b10;
        else if (dep(reg_write_W, write_addr_W, rs_E)) forward_A_E = 2'b01;
        if (dep(reg_write_M, write_addr_M, rt_E))      forward_B_E = 2'b10;
        else if (dep(reg_write_W, write_addr_W, rt_E)) forward_B_E = 2'b01;
    end

`ifdef HAZARD_BRANCH_FWD_EN
    // Branch compare in ID: forward ALU results from MEM, stall while the value is still in EX or is a load in MEM.
    always_comb begin
        forward_A_D  = dep(reg_write_M, write_addr_M, rs_D);
        forward_B_D  = dep(reg_write_M, write_addr_M, rt_D);
        branch_stall = branch_D &&
                       (dep(reg_write_E, write_addr_E, rs_D) || dep(reg_write_E, write_addr_E, rt_D) ||
                        dep(mem_to_reg_M, write_addr_M, rs_D) || dep(mem_to_reg_M, write_addr_M, rt_D));
    end
`else
    // Branches resolve in EX, so ID never forwards or stalls for them.
    logic unused_cfg;
    assign unused_cfg = ^{branch_D, reg_write_E, mem_to_reg_M};

    // Constant-zero branch controls when branch forwarding is compiled out.
    always_comb begin
        forward_A_D  = 1'b0;
        forward_B_D  = 1'b0;
        branch_stall = 1'b0;
    end
`endif

    // Stall sources are ORed so overlapping causes give one stall; nothing here depends on stall itself.
    always_comb begin
        lw_stall  = dep(mem_to_reg_E, write_addr_E, rs_D) || dep(mem_to_reg_E, write_addr_E, rt_D);
        mdu_stall = (hilo_read_D || mdu_op_D) && ((state_q == BUSY) || mdu_start_E);
        stall     = lw_stall | branch_stall | mdu_stall;
        stall_F   = stall;
        stall_D   = stall;
        stall_E   = stall;
        mdu_busy  = (state_q == BUSY);
    end

    // MDU occupancy: counter holds remaining busy cycles minus one; starts while busy are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mdu_cnt_q <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mdu_start_E) begin
                        mdu_cnt_q <= mdu_is_div_E ? DIV_LOAD : MUL_LOAD;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (mdu_cnt_q == 6'd0) begin
                        state_q <= IDLE;
                    end else begin
                        mdu_cnt_q <= mdu_cnt_q - 6'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mdu_cnt_q <= 6'd0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter next state.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stall_count_q <= 16'd0;
        else        stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;

endmodule
